// File: rtl/keypad_entry.sv
// 4x4 active-low keypad scanner with debounce, key decode and a 0..9999 decimal
// entry accumulator (digits append, * clears, # backspaces, A-D report only).
module keypad_entry #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [13:0] value,
  output logic        overflow
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_N      = 4'(DEBOUNCE);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DEB  = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  logic [DW-1:0] dwell;
  logic [1:0]    row;
  logic [3:0]    sync1, sync2;
  logic [11:0]   img;
  logic [15:0]   full;
  logic          last_dwell, scan_end;
  logic [3:0]    cand_idx, cand_code;
  logic          cand_one;
  logic [1:0]    state;
  logic [3:0]    cnt, cnt_inc, stored;
  logic          accept;
  logic [3:0]    acc_code;

  assign row_out    = ~(4'b0001 << row);
  assign last_dwell = (dwell == DWELL_LAST);
  assign scan_end   = last_dwell && (row == 2'd3);
  // Row 3 is latched on the scan-end cycle itself, so take it straight from the synchronizer.
  assign full       = {~sync2, img};
  assign cand_one   = ($countones(full) == 1);
  assign cnt_inc    = cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell <= '0;
      row   <= 2'd0;
      sync1 <= 4'b1111;
      sync2 <= 4'b1111;
      img   <= '0;
    end else begin
      sync1 <= col_in;
      sync2 <= sync1;
      if (last_dwell) begin
        dwell <= '0;
        row   <= row + 2'd1;
        case (row)
          2'd0:    img[3:0]  <= ~sync2;
          2'd1:    img[7:4]  <= ~sync2;
          2'd2:    img[11:8] <= ~sync2;
          default: ;
        endcase
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  always_comb begin
    cand_idx = 4'd0;
    for (int i = 0; i < 16; i++)
      if (full[i]) cand_idx = 4'(i);
  end

  always_comb begin
    case (cand_idx)
      4'd0:  cand_code = 4'd1;
      4'd1:  cand_code = 4'd2;
      4'd2:  cand_code = 4'd3;
      4'd3:  cand_code = 4'd10;
      4'd4:  cand_code = 4'd4;
      4'd5:  cand_code = 4'd5;
      4'd6:  cand_code = 4'd6;
      4'd7:  cand_code = 4'd11;
      4'd8:  cand_code = 4'd7;
      4'd9:  cand_code = 4'd8;
      4'd10: cand_code = 4'd9;
      4'd11: cand_code = 4'd12;
      4'd12: cand_code = 4'd14;
      4'd13: cand_code = 4'd0;
      4'd14: cand_code = 4'd15;
      default: cand_code = 4'd13;
    endcase
  end

  always_comb begin
    accept   = 1'b0;
    acc_code = stored;
    if (scan_end) begin
      if (state == S_IDLE && cand_one && DEB_N == 4'd1) begin
        accept   = 1'b1;
        acc_code = cand_code;
      end else if (state == S_DEB && cand_one && cand_code == stored && cnt_inc == DEB_N) begin
        accept = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      stored <= 4'd0;
    end else if (scan_end) begin
      case (state)
        S_IDLE: if (cand_one) begin
          stored <= cand_code;
          state  <= accept ? S_HELD : S_DEB;
          cnt    <= accept ? 4'd0 : 4'd1;
        end
        S_DEB: if (cand_one && cand_code == stored) begin
          state <= accept ? S_HELD : S_DEB;
          cnt   <= accept ? 4'd0 : cnt_inc;
        end else begin
          state <= S_IDLE;
          cnt   <= 4'd0;
        end
        S_HELD: if (!cand_one) begin
          state <= (DEB_N == 4'd1) ? S_IDLE : S_REL;
          cnt   <= (DEB_N == 4'd1) ? 4'd0 : 4'd1;
        end
        default: if (!cand_one) begin
          state <= (cnt_inc == DEB_N) ? S_IDLE : S_REL;
          cnt   <= (cnt_inc == DEB_N) ? 4'd0 : cnt_inc;
        end else begin
          // Key seen again while releasing: treat as bounce and stay held.
          state <= S_HELD;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      overflow  <= 1'b0;
      value     <= 14'd0;
    end else begin
      key_valid <= accept;
      overflow  <= accept && (acc_code <= 4'd9) && (value >= 14'd1000);
      if (accept) key_code <= acc_code;
      if (key_valid) begin
        if (key_code <= 4'd9) begin
          if (value < 14'd1000) value <= value * 14'd10 + {10'd0, key_code};
        end else if (key_code == 4'd14) begin
          value <= 14'd0;
        end else if (key_code == 4'd15) begin
          value <= value / 14'd10;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a keypad model shorts rows to columns, and a scan-level
// reference model predicts pulses, codes, overflow and the accumulated value.
module tb_keypad_entry;
  localparam int SD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col_in, row_out, key_code;
  logic        key_valid, overflow;
  logic [13:0] value;
  logic [15:0] pressed = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // A pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row_out),
    .key_valid(key_valid), .key_code(key_code), .value(value), .overflow(overflow)
  );

  int kmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  bit armed = 1'b1;
  int run = 0, last = 0, rel = 0, mval = 0;
  bit exp_kv = 1'b0, exp_ovf = 1'b0;
  int exp_code = 0, val_before = 0, val_after = 0;

  function automatic logic [15:0] key(input int code);
    logic [15:0] m = '0;
    for (int i = 0; i < 16; i++) if (kmap[i] == code) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full scan of keypad state m has just ended: decide the outcome.
  task automatic model_scan(input logic [15:0] m);
    int c = -1;
    exp_kv = 1'b0;
    exp_ovf = 1'b0;
    val_before = val_after;
    if ($countones(m) == 1)
      for (int i = 0; i < 16; i++) if (m[i]) c = kmap[i];
    if (armed) begin
      if (c < 0) run = 0;
      else if (run == 0) begin run = 1; last = c; end
      else if (c == last) run++;
      else run = 0;
      if (run == DB) begin
        armed = 1'b0; run = 0; rel = 0;
        exp_kv = 1'b1; exp_code = last;
      end
    end else begin
      if (c < 0) begin
        rel++;
        if (rel == DB) begin armed = 1'b1; rel = 0; end
      end else rel = 0;
    end
    if (exp_kv) begin
      if (last <= 9) begin
        if (mval < 1000) mval = mval * 10 + last;
        else exp_ovf = 1'b1;
      end else if (last == 14) mval = 0;
      else if (last == 15) mval = mval / 10;
    end
    val_after = mval;
  endtask

  // Entered at the scan boundary (row 0, first dwell cycle).
  task automatic run_scan(input logic [15:0] m);
    logic [3:0] er;
    for (int i = 0; i < 16; i++) begin
      er = ~(4'b0001 << (i / SD));
      chk("row_out", 16'(row_out), 16'(er));
      chk("key_valid", 16'(key_valid), 16'((i == 0) && exp_kv));
      chk("overflow", 16'(overflow), 16'((i == 0) && exp_ovf));
      if (i == 0 && exp_kv) chk("key_code", 16'(key_code), 16'(exp_code));
      chk("value", 16'(value), 16'((i == 0) ? val_before : val_after));
      if (i == 0) pressed = m;
      @(negedge clk);
    end
    model_scan(m);
  endtask

  task automatic press(input int code, input int hold, input int relax);
    repeat (hold) run_scan(key(code));
    repeat (relax) run_scan('0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_row_out", 16'(row_out), 16'h000E);
      chk("rst_key_valid", 16'(key_valid), 16'd0);
      chk("rst_value", 16'(value), 16'd0);
      chk("rst_overflow", 16'(overflow), 16'd0);
    end
    rst_n = 1'b1;
    armed = 1'b1; run = 0; rel = 0; mval = 0;
    exp_kv = 1'b0; exp_ovf = 1'b0; val_before = 0; val_after = 0;
  endtask

  initial begin
    int sel, dur;
    logic [15:0] m;
    do_reset();
    repeat (2) run_scan('0);
    // clean press held long, no auto-repeat
    press(5, 15, 4);
    // bouncing contact before settling
    run_scan(key(2)); run_scan('0); run_scan(key(2)); run_scan('0);
    press(2, 4, 4);
    // entry sequence with overflow, backspace, clear, backspace at zero
    press(1, 4, 3); press(2, 4, 3); press(3, 4, 3); press(4, 4, 3);
    press(7, 4, 3); press(15, 4, 3); press(14, 4, 3); press(15, 4, 3);
    press(6, 4, 3); press(12, 4, 3);
    // ghost pair rejected, letter key reported only
    repeat (4) run_scan(key(1) | key(5));
    run_scan('0);
    press(13, 4, 3);
    // reset partway through debouncing while the key stays down
    press(9, 2, 0);
    do_reset();
    press(9, 4, 3);
    // random keypad activity
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 3);
      dur = $urandom_range(1, 5);
      if (sel == 0) m = '0;
      else if (sel == 3) m = key($urandom_range(0, 15)) | key($urandom_range(0, 15));
      else m = key($urandom_range(0, 15));
      repeat (dur) run_scan(m);
    end
    repeat (4) run_scan('0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Scans a 4x4 active-low matrix keypad, debounces it, and decodes each press into a 4-bit key code.
- Assembles decimal key presses into a 0..9999 value, which drives the team's 4-digit seven-segment display.
- This is the input-side counterpart of the display path: the display turns a number into multiplexed digit strobes; this block turns multiplexed row strobes back into a number.

Parameters:
- SCAN_DIV, 1000: clk cycles each row is driven (dwell) before columns are sampled; legal range >= 4.
- DEBOUNCE, 4: consecutive full scans a key state must be stable to be accepted; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- col_in  in  4  keypad columns, active-low, externally pulled up, asynchronous to clk.
- row_out  out  4  keypad row drive, active-low, exactly one bit low at all times.
- key_valid  out  1  one-cycle pulse per accepted key press.
- key_code  out  4  code of the last accepted key; valid when key_valid=1, held afterwards.
- value  out  14  accumulated decimal entry, 0..9999.
- overflow  out  1  one-cycle pulse when a digit is rejected because value >= 1000.

Behaviour:
- Reset (rst_n=0 at posedge clk) sets:
  - row_out=4'b1110, row index r=0, dwell counter=0.
  - key_valid=0, key_code=0, value=0, overflow=0.
  - FSM=IDLE, debounce count=0, 2-FF column synchronizer=4'b1111.
  - Reset mid-scan or mid-debounce discards all partial state.
- Scan timing:
  - row_out[r]=0 and all other rows=1.
  - The dwell counter runs 0..SCAN_DIV-1. On the last dwell cycle, the synchronized columns for row r are latched, then r increments (3 wraps to 0).
  - The column latch at r=3 is the "scan end" event, once per 4*SCAN_DIV cycles.
- Key map (row r, low column c):
  - row0: 1,2,3,A(10)
  - row1: 4,5,6,B(11)
  - row2: 7,8,9,C(12)
  - row3: *(14),0,#(15),D(13)
- Candidate at scan end:
  - Exactly one low bit over all 16 positions: candidate = that key's code.
  - Zero low bits, or two or more low bits (ghost/multi-press reject): candidate = NONE.
- Debounce FSM, evaluated only on scan-end cycles:
  - IDLE: candidate!=NONE -> DEBOUNCE, store code, cnt=1. If DEBOUNCE=1, accept immediately as below.
  - DEBOUNCE:
    - candidate == stored code: cnt++. When cnt reaches DEBOUNCE, accept and go to HELD.
    - Different key or NONE: go to IDLE, cnt=0.
  - Accept: on the next clk, key_valid=1 for exactly one cycle and key_code=stored code.
  - HELD: candidate==NONE -> RELEASE, cnt=1. Otherwise stay in HELD. There is no auto-repeat; changing to another key while held is ignored until release.
  - RELEASE:
    - NONE: cnt++. At cnt==DEBOUNCE, go to IDLE.
    - Any key: go to HELD and reset cnt (release bounce).
- Accumulator: updates in the same cycle key_valid is high, so the new value is visible the cycle after the pulse.
  - Digit d (0..9) with value<1000: value = value*10 + d.
  - Digit d with value>=1000: value unchanged, overflow pulses together with key_valid.
  - * (14): value = 0.
  - # (15): value = value/10 (backspace); at value=0 it stays 0.
  - A-D: reported on key_code only; value unchanged.
- Arithmetic: value*10 is computed in 14 bits. Because digits are accepted only when value<1000, the result never exceeds 9999, so no truncation can occur.
- Simultaneous events: only one scan end per cycle and at most one key_valid per accepted press. Reset overrides everything.

Test Plan (SCAN_DIV=4, DEBOUNCE=3; scan period 16 cycles):
- Reset: hold rst_n=0 for 3 cycles, then release. row_out is 1110 and rotates 1101, 1011, 0111 every 4 cycles; value=0 and key_valid=0 throughout.
- Clean press: pull col1 low while row1 is driven, for 5 scans. Exactly one key_valid pulse with key_code=5, first seen 1 cycle after the 3rd stable scan end; value=5. Holding for a further 10 scans produces no further pulses.
- Bounce: press 2, toggle it every scan for 4 scans, then hold steady. No pulse during toggling; one pulse after 3 stable scans; value=2.
- Entry sequence: press 1,2,3,4 then 7, each with a full release.
  - value goes 1, 12, 123, 1234.
  - The 7 keeps value=1234 with overflow=1.
  - Then # gives 123, then * gives 0.
- Ghost and letter keys: press 1 and 5 together -> no key_valid. Press D -> key_code=13 with value unchanged.
- Reset mid-debounce: assert rst_n=0 after 2 stable scans of key 9, then release while still holding 9. value=0, and key_valid fires only after 3 fresh stable scans.
